// File: rtl/result_display.sv
// ============================================================================
//  Module      : result_display
//  Description : Pages a captured 64-bit DES result across four active-low
//                seven-segment digits, four hex nibbles per page, MSB first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_display (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] result,
    input  logic        resultValid,
    input  logic        nextButton,
    input  logic        prevButton,
    input  logic        clearButton,
    output logic [6:0]  seg3,
    output logic [6:0]  seg2,
    output logic [6:0]  seg1,
    output logic [6:0]  seg0,
    output logic [1:0]  page,
    output logic        hasResult,
    output logic [2:0]  S
);

    typedef enum logic [2:0] {
        ST_EMPTY       = 3'd0,
        ST_SHOW        = 3'd1,
        ST_NEXT_STEP   = 3'd2,
        ST_PREV_STEP   = 3'd3,
        ST_BUTTON_HELD = 3'd4,
        ST_CLEAR       = 3'd5
    } state_t;

    localparam logic [6:0] c_DASH = 7'b0111111;

    state_t      r_state;
    logic [63:0] r_stored;
    logic [1:0]  r_page;

    logic        w_any_pressed;
    logic        w_has_result;
    logic [15:0] w_slice;

    assign w_any_pressed = ~nextButton | ~prevButton | ~clearButton;

    // Capture outranks every button and every state, so it is tested first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stored <= 64'd0;
            r_page   <= 2'd0;
            r_state  <= ST_EMPTY;
        end else if (resultValid) begin
            r_stored <= result;
            r_page   <= 2'd0;
            r_state  <= ST_BUTTON_HELD;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_state <= ST_EMPTY;
                end
                ST_SHOW: begin
                    if (!clearButton) begin
                        r_state <= ST_CLEAR;
                    end else if (!nextButton) begin
                        r_state <= ST_NEXT_STEP;
                    end else if (!prevButton) begin
                        r_state <= ST_PREV_STEP;
                    end else begin
                        r_state <= ST_SHOW;
                    end
                end
                ST_NEXT_STEP: begin
                    r_page  <= r_page + 2'd1;
                    r_state <= ST_BUTTON_HELD;
                end
                ST_PREV_STEP: begin
                    r_page  <= r_page - 2'd1;
                    r_state <= ST_BUTTON_HELD;
                end
                ST_BUTTON_HELD: begin
                    // Waiting for a full release makes one press equal one page.
                    if (w_any_pressed) begin
                        r_state <= ST_BUTTON_HELD;
                    end else begin
                        r_state <= ST_SHOW;
                    end
                end
                ST_CLEAR: begin
                    r_stored <= 64'd0;
                    r_page   <= 2'd0;
                    r_state  <= ST_EMPTY;
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        w_has_result = 1'b0;
        case (r_state)
            ST_SHOW, ST_NEXT_STEP, ST_PREV_STEP,
            ST_BUTTON_HELD, ST_CLEAR: w_has_result = 1'b1;
            default:                  w_has_result = 1'b0;
        endcase
    end

    always_comb begin
        w_slice = r_stored[63:48];
        case (r_page)
            2'd0:    w_slice = r_stored[63:48];
            2'd1:    w_slice = r_stored[47:32];
            2'd2:    w_slice = r_stored[31:16];
            default: w_slice = r_stored[15:0];
        endcase
    end

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign seg3      = w_has_result ? hex7(w_slice[15:12]) : c_DASH;
    assign seg2      = w_has_result ? hex7(w_slice[11:8])  : c_DASH;
    assign seg1      = w_has_result ? hex7(w_slice[7:4])   : c_DASH;
    assign seg0      = w_has_result ? hex7(w_slice[3:0])   : c_DASH;
    assign page      = r_page;
    assign hasResult = w_has_result;
    assign S         = r_state;

endmodule

`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none

module tb_result_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] result;
    logic        resultValid;
    logic        nextButton;
    logic        prevButton;
    logic        clearButton;
    logic [6:0]  seg3, seg2, seg1, seg0;
    logic [1:0]  page;
    logic        hasResult;
    logic [2:0]  S;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G6 = 7'b0000010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GC = 7'b1000110;
    localparam logic [6:0] GD = 7'b0100001;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] GDASH = 7'b0111111;

    result_display dut (
        .clk         (clk),
        .rst         (rst),
        .result      (result),
        .resultValid (resultValid),
        .nextButton  (nextButton),
        .prevButton  (prevButton),
        .clearButton (clearButton),
        .seg3        (seg3),
        .seg2        (seg2),
        .seg1        (seg1),
        .seg0        (seg0),
        .page        (page),
        .hasResult   (hasResult),
        .S           (S)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press and release one button in SHOW; stimulus only.
    task automatic tap(input logic nxt, input logic prv);
        nextButton = ~nxt;
        prevButton = ~prv;
        step();
        step();
        nextButton = 1'b1;
        prevButton = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; result = '0; resultValid = 1'b0;
        nextButton = 1'b1; prevButton = 1'b1; clearButton = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();
        checks++;
        if ({seg3, seg2, seg1, seg0} !== {GDASH, GDASH, GDASH, GDASH}) begin
            errors++; $display("FAIL reset_segs got %h want %h", {seg3, seg2, seg1, seg0}, {GDASH, GDASH, GDASH, GDASH});
        end
        checks++;
        if ({hasResult, page, S} !== 6'b0_00_000) begin
            errors++; $display("FAIL reset_regs got has=%b page=%0d S=%0d want 0 0 0", hasResult, page, S);
        end
        // Buttons are ignored while EMPTY.
        nextButton = 1'b0; clearButton = 1'b0;
        step(); step();
        nextButton = 1'b1; clearButton = 1'b1;
        checks++;
        if (S !== 3'd0 || page !== 2'd0) begin
            errors++; $display("FAIL empty_ignores_buttons got S=%0d page=%0d want 0 0", S, page);
        end
    endtask

    task automatic test_capture();
        result = 64'h0123456789ABCDEF; resultValid = 1'b1;
        step();
        resultValid = 1'b0;
        checks++;
        if ({seg3, seg2, seg1, seg0} !== {G0, G1, G2, G3}) begin
            errors++; $display("FAIL capture_page0 got %h want %h", {seg3, seg2, seg1, seg0}, {G0, G1, G2, G3});
        end
        checks++;
        if (page !== 2'd0 || hasResult !== 1'b1 || S !== 3'd4) begin
            errors++; $display("FAIL capture_regs got page=%0d has=%b S=%0d want 0 1 4", page, hasResult, S);
        end
        step();
        checks++;
        if (S !== 3'd1) begin
            errors++; $display("FAIL capture_show got S=%0d want 1", S);
        end
    endtask

    task automatic test_paging();
        logic [1:0]  exp_page [4];
        logic [27:0] exp_segs [4];
        exp_page = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_segs = '{{G4, G5, G6, G7}, {G8, G9, GA, GB}, {GC, GD, GE, GF}, {G0, G1, G2, G3}};
        for (int i = 0; i < 4; i++) begin
            tap(1'b1, 1'b0);
            checks++;
            if (page !== exp_page[i] || S !== 3'd1) begin
                errors++; $display("FAIL next_page%0d got page=%0d S=%0d want %0d 1", i, page, S, exp_page[i]);
            end
            checks++;
            if ({seg3, seg2, seg1, seg0} !== exp_segs[i]) begin
                errors++; $display("FAIL next_segs%0d got %h want %h", i, {seg3, seg2, seg1, seg0}, exp_segs[i]);
            end
        end
        // Step-by-step timing of one prev press from page 0.
        prevButton = 1'b0;
        step();
        checks++;
        if (S !== 3'd3 || page !== 2'd0) begin
            errors++; $display("FAIL prev_step got S=%0d page=%0d want 3 0", S, page);
        end
        step();
        checks++;
        if (S !== 3'd4 || page !== 2'd3) begin
            errors++; $display("FAIL prev_wrap got S=%0d page=%0d want 4 3", S, page);
        end
        prevButton = 1'b1;
        step();
        checks++;
        if (S !== 3'd1 || seg0 !== GF) begin
            errors++; $display("FAIL prev_release got S=%0d seg0=%b want 1 %b", S, seg0, GF);
        end
    endtask

    task automatic test_hold();
        int bad = 0;
        nextButton = 1'b0;
        step(); step();
        for (int i = 0; i < 18; i++) begin
            step();
            if (S !== 3'd4 || page !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL hold_once got %0d bad cycles, S=%0d page=%0d want 0 bad S=4 page=0", bad, S, page);
        end
        nextButton = 1'b1;
        step();
        checks++;
        if (S !== 3'd1 || page !== 2'd0) begin
            errors++; $display("FAIL hold_release got S=%0d page=%0d want 1 0", S, page);
        end
        nextButton = 1'b0; prevButton = 1'b0;
        step();
        checks++;
        if (S !== 3'd2) begin
            errors++; $display("FAIL both_next_wins got S=%0d want 2", S);
        end
        step();
        nextButton = 1'b1;
        step();
        checks++;
        if (S !== 3'd4 || page !== 2'd1) begin
            errors++; $display("FAIL both_held got S=%0d page=%0d want 4 1", S, page);
        end
        prevButton = 1'b1;
        step();
        checks++;
        if (S !== 3'd1 || page !== 2'd1) begin
            errors++; $display("FAIL both_release got S=%0d page=%0d want 1 1", S, page);
        end
    endtask

    task automatic test_clear_then_capture();
        clearButton = 1'b0; nextButton = 1'b0;
        step();
        clearButton = 1'b1;
        checks++;
        if (S !== 3'd5 || hasResult !== 1'b1) begin
            errors++; $display("FAIL clear_state got S=%0d has=%b want 5 1", S, hasResult);
        end
        step();
        checks++;
        if (S !== 3'd0 || hasResult !== 1'b0 || page !== 2'd0 ||
            {seg3, seg2, seg1, seg0} !== {GDASH, GDASH, GDASH, GDASH}) begin
            errors++; $display("FAIL clear_empty got S=%0d has=%b page=%0d segs=%h want 0 0 0 dashes", S, hasResult, page, {seg3, seg2, seg1, seg0});
        end
        result = 64'h8888888888888888; resultValid = 1'b1;
        step();
        resultValid = 1'b0;
        checks++;
        if ({seg3, seg2, seg1, seg0} !== {G8, G8, G8, G8} || page !== 2'd0 || S !== 3'd4) begin
            errors++; $display("FAIL held_capture got segs=%h page=%0d S=%0d want %h 0 4", {seg3, seg2, seg1, seg0}, page, S, {G8, G8, G8, G8});
        end
        step(); step();
        checks++;
        if (S !== 3'd4) begin
            errors++; $display("FAIL held_capture_wait got S=%0d want 4", S);
        end
        nextButton = 1'b1;
        step();
        checks++;
        if (S !== 3'd1 || page !== 2'd0) begin
            errors++; $display("FAIL held_capture_release got S=%0d page=%0d want 1 0", S, page);
        end
    endtask

    task automatic test_back_to_back();
        // Capture in the same cycle as clear must win.
        clearButton = 1'b0;
        result = 64'hFEDCBA9876543210; resultValid = 1'b1;
        step();
        result = 64'h0000000000000000;
        step();
        result = 64'hF0F0F0F0F0F0F0F0;
        step();
        checks++;
        if (S !== 3'd4 || {seg3, seg2, seg1, seg0} !== {GF, G0, GF, G0}) begin
            errors++; $display("FAIL recapture got S=%0d segs=%h want 4 %h", S, {seg3, seg2, seg1, seg0}, {GF, G0, GF, G0});
        end
        resultValid = 1'b0; clearButton = 1'b1;
        step();
        checks++;
        if (S !== 3'd1 || hasResult !== 1'b1) begin
            errors++; $display("FAIL recapture_show got S=%0d has=%b want 1 1", S, hasResult);
        end
    endtask

    task automatic test_reset_mid_step();
        tap(1'b1, 1'b0);
        nextButton = 1'b0;
        step();
        checks++;
        if (S !== 3'd2 || page !== 2'd1) begin
            errors++; $display("FAIL pre_reset got S=%0d page=%0d want 2 1", S, page);
        end
        rst = 1'b1;
        step();
        rst = 1'b0; nextButton = 1'b1;
        checks++;
        if (S !== 3'd0 || page !== 2'd0 || hasResult !== 1'b0 ||
            {seg3, seg2, seg1, seg0} !== {GDASH, GDASH, GDASH, GDASH}) begin
            errors++; $display("FAIL mid_reset got S=%0d page=%0d has=%b segs=%h want 0 0 0 dashes", S, page, hasResult, {seg3, seg2, seg1, seg0});
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_paging();
        test_hold();
        test_clear_then_capture();
        test_back_to_back();
        test_reset_mid_step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_display.md
# result_display

Presents a 64-bit DES result to the user as sixteen hex digits, four at a time, on four active-low seven-segment displays. It is the output-side counterpart of the switch/button hex entry path: entry loads nibbles most-significant first, and this block pages through them in the same order. The captured result stays shown until the user clears it or a new result arrives. It sits between the DES core output and the board's HEX displays, with user paging via the active-low board pushbuttons.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; one clock domain.
- rst  input  1  reset; synchronous, active-high.
- result  input  64  DES output word.
- resultValid  input  1  capture strobe for `result`; sampled every cycle.
- nextButton  input  1  active-low; advance one page.
- prevButton  input  1  active-low; go back one page.
- clearButton  input  1  active-low; discard the shown result.
- seg3, seg2, seg1, seg0  output  7 each  active-low segments, ordered {g,f,e,d,c,b,a}; seg3 is the leftmost digit.
- page  output  2  current page, 0..3.
- hasResult  output  1  high while a result is held.
- S  output  3  current state, for debug LEDs.

## Operation
- Registers: `stored[63:0]`, `page[1:0]`, `S[2:0]`.
- Page p shows `stored[63-16p -: 16]`; seg3 shows the top nibble of that slice and seg0 the bottom nibble.
  - Page 0 shows bits [63:60] down to [51:48].
  - Page 3 shows bits [15:12] down to [3:0].
- Decode: standard hex glyphs. Required values: 0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110.
- In EMPTY, all four digits show a dash, 7'b0111111.
- State encodings:
  - EMPTY = 0
  - SHOW = 1
  - NEXT_STEP = 2
  - PREV_STEP = 3
  - BUTTON_HELD = 4
  - CLEAR = 5
  - codes 6 and 7 go to EMPTY on the next edge.
- Capture has top priority, in any state:
  - resultValid high at an edge loads `stored <= result` and `page <= 0`, and sets S to BUTTON_HELD.
  - Capture overrides every button action in that cycle.
- Transitions when resultValid is low:
  - EMPTY: stays in EMPTY; all buttons are ignored.
  - SHOW: checks buttons in this order.
    - !clearButton goes to CLEAR.
    - Otherwise !nextButton goes to NEXT_STEP.
    - Otherwise !prevButton goes to PREV_STEP.
    - Otherwise stays in SHOW.
  - NEXT_STEP: `page <= page + 1`, wrapping 3 -> 0; then BUTTON_HELD.
  - PREV_STEP: `page <= page - 1`, wrapping 0 -> 3; then BUTTON_HELD.
  - BUTTON_HELD: stays while any of the three buttons is low; goes to SHOW once all are high. Each press therefore moves exactly one page.
  - CLEAR: `stored <= 0`, `page <= 0`; then EMPTY.
- hasResult is 1 in SHOW, NEXT_STEP, PREV_STEP, BUTTON_HELD and CLEAR, and 0 in EMPTY.
  - Consequence: hasResult rises on the same edge as a capture, and falls on the edge that leaves CLEAR.

## Timing
- Reset values at the first edge with rst high:
  - stored = 0, page = 0, S = EMPTY, hasResult = 0.
  - All segments show dashes.
- Segment outputs are a combinational decode of the registered `stored`, `page` and `S`. They change in the same cycle as the register update; there is no extra pipeline stage.
- Button press seen low at edge k:
  - edge k: S = NEXT_STEP or PREV_STEP.
  - edge k+1: page updates and S = BUTTON_HELD.
  - Release seen at edge m: S = SHOW at edge m.
  - Fastest next press is accepted at edge m+1.
- Capture latency: resultValid high at edge k means the new digits and page 0 are visible after edge k.
  - If no button is held, S = SHOW at edge k+1.
- Simultaneous presses in SHOW: clear beats next, and next beats prev. Any button still held keeps S in BUTTON_HELD.
- resultValid held high for several cycles re-captures each cycle; S stays in BUTTON_HELD until resultValid falls.
- rst asserted mid-step or mid-hold overrides every other input and returns all registers to their reset values at that edge.

## Test plan
- Reset, then idle 5 cycles -> all segments 7'b0111111, hasResult = 0, page = 0, S = 0.
- Capture and read page 0: result = 64'h0123456789ABCDEF with resultValid pulsed for 1 cycle.
  - After the capture edge: seg3..seg0 decode 0,1,2,3; page = 0; hasResult = 1.
  - Next cycle: S = SHOW.
- Paging with wrap:
  - Press and release next 4 times -> page goes 1, 2, 3, 0.
  - Page 3 shows C, D, E, F (seg0 = F = 7'b0001110).
  - Press prev once from page 0 -> page = 3.
- Hold behaviour:
  - Hold next low for 20 cycles -> page increments exactly once and S stays 4 until release.
  - Press next and prev together -> page increments once.
- Clear, then a mid-hold capture:
  - Press clear in SHOW -> S goes 5, then 0; dashes shown; stored = 0; hasResult = 0.
  - Then pulse resultValid = 64'h8888888888888888 while next is held -> digits show 8 (7'b0000000), page = 0, S = 4 until next is released.
- Reset during NEXT_STEP -> next edge gives page = 0, S = EMPTY, stored = 0.
